// File: rtl/dual_issue_hazard_unit.sv
// ---------------------------------------------------------------------------
// dual_issue_hazard_unit
//
// In-order hazard check and issue splitting for a multi-lane decode bundle.
// Each lane is compared with every older lane of the same bundle for RAW
// (older rd feeds a younger rs1/rs2) and WAW (both write the same rd)
// conflicts. The longest conflict-free prefix of the still-pending lanes
// issues. Lanes after that prefix are held, so a dependent bundle drains
// over several advance cycles. Lane 0 is the oldest lane.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   bundle_valid    decode presents a valid bundle
//   rd_i/rs1_i/rs2_i packed register indices, lane k at [k*REG_ADDR_W +: REG_ADDR_W]
//   reg_write_i     per-lane write enable for rd
//   advance_i       downstream accepts this cycle's issue
//   flush_i         drop the bundle and any split progress
//   issue_mask_o    lanes issued this cycle (combinational)
//   stall_decode_o  bundle not fully issued; decode holds (combinational)
//   split_active_o  a partially issued bundle is in flight (registered)
//   split_count_o   saturating count of split steps (registered)
// ---------------------------------------------------------------------------

// Pairwise conflict check: does older lane (src) block younger lane (dst)?
// Register 0 never carries a dependency. A write-disabled older lane
// cannot create a hazard.
module dual_issue_hazard_pair #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src_rd,
    input  logic                  src_write,
    input  logic [REG_ADDR_W-1:0] dst_rd,
    input  logic [REG_ADDR_W-1:0] dst_rs1,
    input  logic [REG_ADDR_W-1:0] dst_rs2,
    input  logic                  dst_write,
    output logic                  hit
);
    logic raw;
    logic waw;

    always_comb begin
        raw = (src_rd == dst_rs1) || (src_rd == dst_rs2);
        waw = dst_write && (src_rd == dst_rd);
        hit = src_write && (src_rd != '0) && (raw || waw);
    end
endmodule

module dual_issue_hazard_unit #(
    parameter int NUM_LANES  = 2,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            bundle_valid,
    input  logic [NUM_LANES*REG_ADDR_W-1:0] rd_i,
    input  logic [NUM_LANES*REG_ADDR_W-1:0] rs1_i,
    input  logic [NUM_LANES*REG_ADDR_W-1:0] rs2_i,
    input  logic [NUM_LANES-1:0]            reg_write_i,
    input  logic                            advance_i,
    input  logic                            flush_i,
    output logic [NUM_LANES-1:0]            issue_mask_o,
    output logic                            stall_decode_o,
    output logic                            split_active_o,
    output logic [CNT_W-1:0]                split_count_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        FULL  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    // Packed views of the flat lane buses (same bit layout).
    logic [NUM_LANES-1:0][REG_ADDR_W-1:0] rd;
    logic [NUM_LANES-1:0][REG_ADDR_W-1:0] rs1;
    logic [NUM_LANES-1:0][REG_ADDR_W-1:0] rs2;

    assign rd  = rd_i;
    assign rs1 = rs1_i;
    assign rs2 = rs2_i;

    state_t                 state, state_next;
    logic [NUM_LANES-1:0]   done_mask, done_next;
    logic [CNT_W-1:0]       split_cnt, split_cnt_next;

    logic [NUM_LANES-1:0]                 pending;
    logic [NUM_LANES-1:0][NUM_LANES-1:0]  pair_hit;    // [younger][older]
    logic [NUM_LANES-1:0]                 lane_hazard;
    logic [NUM_LANES-1:0]                 blocked;
    logic [NUM_LANES-1:0]                 issue_raw;
    logic                                 squash;
    logic                                 stall_raw;

    assign pending = bundle_valid ? ~done_mask : '0;
    assign squash  = rst || flush_i;

    // Static pairwise comparator array. Only older->younger pairs exist;
    // the rest of the matrix is tied off.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_dst
        for (genvar j = 0; j < NUM_LANES; j++) begin : g_src
            if (j < i) begin : g_pair
                dual_issue_hazard_pair #(
                    .REG_ADDR_W (REG_ADDR_W)
                ) u_pair (
                    .src_rd    (rd[j]),
                    .src_write (reg_write_i[j]),
                    .dst_rd    (rd[i]),
                    .dst_rs1   (rs1[i]),
                    .dst_rs2   (rs2[i]),
                    .dst_write (reg_write_i[i]),
                    .hit       (pair_hit[i][j])
                );
            end else begin : g_none
                assign pair_hit[i][j] = 1'b0;
            end
        end

        // Already-issued lanes neither block nor get blocked.
        assign lane_hazard[i] = pending[i] && |(pair_hit[i] & pending);
    end

    // Once some lane is blocked, every younger lane is held too, which keeps
    // issue strictly in order. The oldest pending lane has no pending
    // predecessor, so it is never blocked and progress is guaranteed.
    always_comb begin
        blocked    = '0;
        blocked[0] = lane_hazard[0];
        for (int i = 1; i < NUM_LANES; i++) begin
            blocked[i] = blocked[i-1] || lane_hazard[i];
        end
        issue_raw = pending & ~blocked;
        stall_raw = bundle_valid && (issue_raw != pending);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FULL;
            done_mask <= '0;
            split_cnt <= '0;
        end else begin
            state     <= state_next;
            done_mask <= done_next;
            split_cnt <= split_cnt_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // Progress is only recorded for a valid bundle that downstream accepts.
    // Flush takes priority over advance and never bumps the counter.
    always_comb begin
        state_next     = state;
        done_next      = done_mask;
        split_cnt_next = split_cnt;
        if (flush_i) begin
            state_next = FULL;
            done_next  = '0;
        end else if (bundle_valid && advance_i) begin
            if (stall_raw) begin
                // Issued lanes are non-empty here, so done_next != 0.
                state_next = SPLIT;
                done_next  = done_mask | issue_raw;
                if (split_cnt != CNT_MAX) begin
                    split_cnt_next = split_cnt + 1'b1;
                end
            end else begin
                state_next = FULL;
                done_next  = '0;
            end
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        issue_mask_o   = squash ? '0 : issue_raw;
        stall_decode_o = !squash && stall_raw;
        split_active_o = (state == SPLIT);
        split_count_o  = split_cnt;
    end
endmodule

// File: tb/tb_dual_issue_hazard_unit.sv
module tb_dual_issue_hazard_unit;
    localparam int NL = 4;
    localparam int RW = 5;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bundle_valid = 1'b0;
    logic advance_i = 1'b0;
    logic flush_i = 1'b0;
    logic [RW-1:0] rd [NL];
    logic [RW-1:0] rs1[NL];
    logic [RW-1:0] rs2[NL];
    logic [NL-1:0] wr;
    logic [NL*RW-1:0] rd_v, rs1_v, rs2_v;

    logic [NL-1:0] issue_mask;
    logic          stall;
    logic          split_active;
    logic [CW-1:0] split_count;

    int  checks = 0;
    int  failures = 0;
    bit  chk_en = 1'b0;

    // Behavioural model state: which lanes of the current bundle went out,
    // and how many split steps have been seen.
    bit  m_done[NL];
    int  m_cnt = 0;

    always #5 clk = ~clk;

    always_comb begin
        rd_v = '0; rs1_v = '0; rs2_v = '0;
        for (int k = 0; k < NL; k++) begin
            rd_v [k*RW +: RW] = rd[k];
            rs1_v[k*RW +: RW] = rs1[k];
            rs2_v[k*RW +: RW] = rs2[k];
        end
    end

    dual_issue_hazard_unit #(
        .NUM_LANES  (NL),
        .REG_ADDR_W (RW),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bundle_valid   (bundle_valid),
        .rd_i           (rd_v),
        .rs1_i          (rs1_v),
        .rs2_i          (rs2_v),
        .reg_write_i    (wr),
        .advance_i      (advance_i),
        .flush_i        (flush_i),
        .issue_mask_o   (issue_mask),
        .stall_decode_o (stall),
        .split_active_o (split_active),
        .split_count_o  (split_count)
    );

    function automatic bit depends(int j, int i);
        return wr[j] && rd[j] != 0 &&
               (rd[j] == rs1[i] || rd[j] == rs2[i] || (wr[i] && rd[j] == rd[i]));
    endfunction

    function automatic bit model_split();
        bit any = 0;
        for (int k = 0; k < NL; k++) if (m_done[k]) any = 1;
        return any;
    endfunction

    // Walk lanes oldest first; stop at the first pending lane that depends
    // on an older pending lane.
    function automatic void model_eval(output logic [NL-1:0] iss, output logic stl);
        bit pend[NL];
        bit stop;
        iss = '0;
        stl = 1'b0;
        stop = 0;
        if (rst || flush_i) return;
        for (int i = 0; i < NL; i++) pend[i] = bundle_valid && !m_done[i];
        for (int i = 0; i < NL; i++) begin
            if (pend[i] && !stop) begin
                for (int j = 0; j < i; j++) if (pend[j] && depends(j, i)) stop = 1;
                if (!stop) iss[i] = 1'b1;
            end
        end
        for (int i = 0; i < NL; i++) if (pend[i] && !iss[i]) stl = 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        logic [NL-1:0] ei;
        logic          es;
        if (chk_en) begin
            model_eval(ei, es);
            check("model issue_mask", 32'(issue_mask), 32'(ei));
            check("model stall", 32'(stall), 32'(es));
            check("model split_active", 32'(split_active), 32'(model_split()));
            check("model split_count", 32'(split_count), 32'(m_cnt));
        end
    end

    // Model state update on the clock edge; inputs are stable here.
    always @(posedge clk) begin
        logic [NL-1:0] ei;
        logic          es;
        model_eval(ei, es);
        if (rst) begin
            for (int k = 0; k < NL; k++) m_done[k] = 0;
            m_cnt = 0;
        end else if (flush_i) begin
            for (int k = 0; k < NL; k++) m_done[k] = 0;
        end else if (bundle_valid && advance_i) begin
            if (es) begin
                for (int k = 0; k < NL; k++) if (ei[k]) m_done[k] = 1;
                if (m_cnt < CMAX) m_cnt++;
            end else begin
                for (int k = 0; k < NL; k++) m_done[k] = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_bundle();
        for (int k = 0; k < NL; k++) begin
            rd[k] = '0; rs1[k] = '0; rs2[k] = '0;
        end
        wr = '0;
    endtask

    task automatic load_chain();
        clr_bundle();
        rd[0] = 1; wr[0] = 1;
        rs1[1] = 1; rd[1] = 2; wr[1] = 1;
        rs2[2] = 2; rd[2] = 3; wr[2] = 1;
        rs1[3] = 3;
    endtask

    initial begin
        logic [NL-1:0] em;
        clr_bundle();
        rst = 1'b1;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("reset issue_mask", 32'(issue_mask), 32'h0);
        check("reset stall", 32'(stall), 32'h0);
        check("reset split_active", 32'(split_active), 32'h0);
        check("reset split_count", 32'(split_count), 32'h0);
        cyc();

        // RAW lane1 <- lane0 through r5
        rd[0] = 5; wr[0] = 1; rs1[1] = 5;
        bundle_valid = 1; advance_i = 1;
        @(negedge clk);
        check("raw c0 mask", 32'(issue_mask), 32'b0001);
        check("raw c0 stall", 32'(stall), 32'h1);
        cyc();
        @(negedge clk);
        check("raw c1 mask", 32'(issue_mask), 32'b1110);
        check("raw c1 stall", 32'(stall), 32'h0);
        check("raw c1 split_active", 32'(split_active), 32'h1);
        cyc();
        bundle_valid = 0;
        @(negedge clk);
        check("raw c2 split_active", 32'(split_active), 32'h0);
        check("raw c2 split_count", 32'(split_count), 32'h1);
        cyc();

        // x0 and write-disabled producers never block
        clr_bundle();
        wr[0] = 1; wr[1] = 1;
        bundle_valid = 1;
        @(negedge clk);
        check("x0 mask", 32'(issue_mask), 32'b1111);
        check("x0 stall", 32'(stall), 32'h0);
        cyc();
        rd[0] = 7; wr[0] = 0; rs1[1] = 7; wr[1] = 0;
        @(negedge clk);
        check("nowrite mask", 32'(issue_mask), 32'b1111);
        check("nowrite count", 32'(split_count), 32'h1);
        cyc();

        rst = 1; bundle_valid = 0;
        cyc();
        rst = 0;

        // full dependency chain drains one lane per advance
        load_chain();
        bundle_valid = 1; advance_i = 1;
        for (int s = 0; s < NL; s++) begin
            em = 4'b0001;
            em = em << s;
            @(negedge clk);
            check("chain mask", 32'(issue_mask), 32'(em));
            check("chain stall", 32'(stall), 32'(s != NL - 1));
            cyc();
        end
        bundle_valid = 0;
        @(negedge clk);
        check("chain count", 32'(split_count), 32'd3);
        check("chain split_active", 32'(split_active), 32'h0);
        cyc();

        rst = 1;
        cyc();
        rst = 0;

        // WAW lane2 <- lane0 on r9
        clr_bundle();
        rd[0] = 9; wr[0] = 1; rd[2] = 9; wr[2] = 1;
        bundle_valid = 1; advance_i = 1;
        @(negedge clk);
        check("waw c0 mask", 32'(issue_mask), 32'b0011);
        check("waw c0 stall", 32'(stall), 32'h1);
        cyc();
        @(negedge clk);
        check("waw c1 mask", 32'(issue_mask), 32'b1100);
        check("waw c1 stall", 32'(stall), 32'h0);
        cyc();

        // hold mid-split, then flush together with advance
        load_chain();
        @(negedge clk);
        check("hold c0 mask", 32'(issue_mask), 32'b0001);
        cyc();
        advance_i = 0;
        repeat (3) begin
            @(negedge clk);
            check("hold mask", 32'(issue_mask), 32'b0010);
            check("hold split_active", 32'(split_active), 32'h1);
            check("hold count", 32'(split_count), 32'h2);
            cyc();
        end
        flush_i = 1; advance_i = 1;
        @(negedge clk);
        check("flush mask", 32'(issue_mask), 32'h0);
        check("flush stall", 32'(stall), 32'h0);
        cyc();
        flush_i = 0; advance_i = 0;
        @(negedge clk);
        check("post flush split_active", 32'(split_active), 32'h0);
        check("post flush count", 32'(split_count), 32'h2);
        check("post flush mask", 32'(issue_mask), 32'b0001);
        cyc();

        // counter saturation, then reset mid-split
        advance_i = 1;
        repeat (4) cyc();
        bundle_valid = 0;
        @(negedge clk);
        check("sat count", 32'(split_count), 32'd3);
        cyc();
        bundle_valid = 1;
        cyc();
        @(negedge clk);
        check("pre rst split_active", 32'(split_active), 32'h1);
        rst = 1;
        #1;
        check("in rst mask", 32'(issue_mask), 32'h0);
        check("in rst stall", 32'(stall), 32'h0);
        cyc();
        rst = 0; bundle_valid = 0; advance_i = 0;
        @(negedge clk);
        check("post rst split_active", 32'(split_active), 32'h0);
        check("post rst count", 32'(split_count), 32'h0);
        check("post rst mask", 32'(issue_mask), 32'h0);
        cyc();

        // randomized traffic; bundle only changes when nothing is in flight
        // or the change is covered by flush/reset
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 64) == 0;
            flush_i = ($urandom % 20) == 0;
            advance_i = ($urandom % 4) != 0;
            if (!model_split() || flush_i || rst) begin
                bundle_valid = ($urandom % 8) != 0;
                for (int k = 0; k < NL; k++) begin
                    rd[k]  = RW'($urandom_range(0, 3));
                    rs1[k] = RW'($urandom_range(0, 3));
                    rs2[k] = RW'($urandom_range(0, 3));
                    wr[k]  = ($urandom % 4) != 0;
                end
            end
            cyc();
        end
        rst = 0; flush_i = 0; advance_i = 0; bundle_valid = 0;
        cyc();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
